hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 30 +++
 rtl/hazard_ctrl.sv | 116 +++++++++++
 tb/tb_hazard_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit signal bundle: instruction/status from the pipeline
// (master) and stall/flush/forward controls back from hazard_ctrl (slave).
interface hazard_ctrl_if #(
   parameter int Width = 32
);
   logic [Width-1:0] ir_FD;
   logic [Width-1:0] ir_EM;
   logic             reg_wrEM;
   logic             br_taken;
   logic             dmem_req;
   logic             dmem_ready;
   logic             stall_FD;
   logic             stall_EM;
   logic             bubble_EM;
   logic             flush;
   logic             fora;
   logic             forb;
   logic             fora_wb;
   logic             forb_wb;

   modport master (
      output ir_FD, ir_EM, reg_wrEM, br_taken, dmem_req, dmem_ready,
      input  stall_FD, stall_EM, bubble_EM, flush, fora, forb, fora_wb, forb_wb
   );

   modport slave (
      input  ir_FD, ir_EM, reg_wrEM, br_taken, dmem_req, dmem_ready,
      output stall_FD, stall_EM, bubble_EM, flush, fora, forb, fora_wb, forb_wb
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard unit for a FD/EM/MW pipeline: stalls, flushes and forwarding selects.
// Optional stall-cycle counter port stall_cnt when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
   parameter int Width = 32
) (
   input  logic          clk,
   input  logic          rst,
   hazard_ctrl_if.slave  hif
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]   stall_cnt
`endif
);
   typedef enum logic [1:0] {RUN, LDUSE, MEMWAIT} state_t;

   state_t     state, state_nxt;
   logic       lat_a, lat_b, lat_a_nxt, lat_b_nxt;
   logic [4:0] rs1, rs2, rd;
   logic       ld_EM, hit_a, hit_b;
   logic       stall_fd, stall_em, bubble_em, flush, fora, forb, fora_wb, forb_wb;
   logic       unused_bits;

   assign rs1   = hif.ir_FD[19:15];
   assign rs2   = hif.ir_FD[24:20];
   assign rd    = hif.ir_EM[11:7];
   assign ld_EM = (hif.ir_EM[6:0] == 7'b0000011);
   assign hit_a = hif.reg_wrEM && (rd != 5'd0) && (rd == rs1);
   assign hit_b = hif.reg_wrEM && (rd != 5'd0) && (rd == rs2);

   assign unused_bits = ^{hif.ir_FD[Width-1:25], hif.ir_FD[14:0], hif.ir_EM[Width-1:12]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         lat_a <= 1'b0;
         lat_b <= 1'b0;
      end else begin
         state <= state_nxt;
         lat_a <= lat_a_nxt;
         lat_b <= lat_b_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      lat_a_nxt = lat_a;
      lat_b_nxt = lat_b;
      stall_fd  = 1'b0;
      stall_em  = 1'b0;
      bubble_em = 1'b0;
      flush     = 1'b0;
      fora      = 1'b0;
      forb      = 1'b0;
      fora_wb   = 1'b0;
      forb_wb   = 1'b0;
      if (!rst) begin
         case (state)
            RUN: begin
               if (hif.dmem_req && !hif.dmem_ready) begin
                  stall_fd  = 1'b1;
                  stall_em  = 1'b1;
                  state_nxt = MEMWAIT;
               end else if (hif.br_taken) begin
                  // Branch wins over load-use: the dependent FD instruction is discarded anyway.
                  flush = 1'b1;
                  fora  = hit_a && !ld_EM;
                  forb  = hit_b && !ld_EM;
               end else if (ld_EM && (hit_a || hit_b)) begin
                  stall_fd  = 1'b1;
                  bubble_em = 1'b1;
                  lat_a_nxt = hit_a;
                  lat_b_nxt = hit_b;
                  state_nxt = LDUSE;
               end else begin
                  fora = hit_a && !ld_EM;
                  forb = hit_b && !ld_EM;
               end
            end
            LDUSE: begin
               // Load result now sits in MW; pick it up from the writeback path.
               fora_wb   = lat_a;
               forb_wb   = lat_b;
               state_nxt = RUN;
            end
            MEMWAIT: begin
               if (!hif.dmem_ready) begin
                  stall_fd = 1'b1;
                  stall_em = 1'b1;
               end else begin
                  flush     = hif.br_taken;
                  state_nxt = RUN;
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   assign hif.stall_FD  = stall_fd;
   assign hif.stall_EM  = stall_em;
   assign hif.bubble_EM = bubble_em;
   assign hif.flush     = flush;
   assign hif.fora      = fora;
   assign hif.forb      = forb;
   assign hif.fora_wb   = fora_wb;
   assign hif.forb_wb   = forb_wb;

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (stall_fd && (stall_cnt != 32'hFFFF_FFFF))
         stall_cnt <= stall_cnt + 32'd1;
   end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic against a rule-level reference model.
module tb_hazard_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   logic [7:0] o;

   hazard_ctrl_if #(.Width(32)) hif ();

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt;
   hazard_ctrl #(.Width(32)) dut (.clk(clk), .rst(rst), .hif(hif), .stall_cnt(stall_cnt));
`else
   hazard_ctrl #(.Width(32)) dut (.clk(clk), .rst(rst), .hif(hif));
`endif

   always #5 clk = ~clk;

   // {stall_FD, stall_EM, bubble_EM, flush, fora, forb, fora_wb, forb_wb}
   function automatic logic [7:0] obs();
      return {hif.stall_FD, hif.stall_EM, hif.bubble_EM, hif.flush,
              hif.fora, hif.forb, hif.fora_wb, hif.forb_wb};
   endfunction

   function automatic logic [31:0] mk_r(input logic [4:0] rd, rs1, rs2);
      return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] mk_lw(input logic [4:0] rd, rs1);
      return {12'd0, rs1, 3'b010, rd, 7'b0000011};
   endfunction

   function automatic logic [31:0] mk_sw(input logic [4:0] rs2, rs1);
      return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
   endfunction

   task automatic set_in(input logic [31:0] fd, em, input logic wr, br, req, rdy);
      hif.ir_FD      = fd;
      hif.ir_EM      = em;
      hif.reg_wrEM   = wr;
      hif.br_taken   = br;
      hif.dmem_req   = req;
      hif.dmem_ready = rdy;
      #2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_in(mk_r(6, 5, 7), mk_lw(5, 1), 1'b1, 1'b1, 1'b1, 1'b0);
      o = obs(); tests++;
      if (o !== 8'h00) begin fails++; $display("FAIL reset_hold: got %b want %b", o, 8'h00); end
      tick();
      set_in(mk_r(6, 5, 7), mk_r(5, 1, 2), 1'b1, 1'b0, 1'b1, 1'b0);
      o = obs(); tests++;
      if (o !== 8'h00) begin fails++; $display("FAIL reset_hold2: got %b want %b", o, 8'h00); end
`ifdef HAZARD_PERF_CNT_EN
      tests++;
      if (stall_cnt !== 32'd0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
`endif
      tick();
      rst = 1'b0;
      set_in(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      o = obs(); tests++;
      if (o !== 8'h00) begin fails++; $display("FAIL reset_idle: got %b want %b", o, 8'h00); end
      tick();
   endtask

   task automatic test_forward();
      // add x5 in EM, sub x6,x5,x7 in FD
      set_in(mk_r(6, 5, 7), mk_r(5, 1, 2), 1'b1, 1'b0, 1'b0, 1'b0);
      o = obs(); tests++;
      if (o !== 8'h08) begin fails++; $display("FAIL fwd_rs1: got %b want %b", o, 8'h08); end
      tick();
      set_in(mk_r(6, 7, 5), mk_r(5, 1, 2), 1'b1, 1'b0, 1'b0, 1'b0);
      o = obs(); tests++;
      if (o !== 8'h04) begin fails++; $display("FAIL fwd_rs2: got %b want %b", o, 8'h04); end
      tick();
      set_in(mk_r(6, 5, 5), mk_r(5, 1, 2), 1'b0, 1'b0, 1'b0, 1'b0);
      o = obs(); tests++;
      if (o !== 8'h00) begin fails++; $display("FAIL fwd_nowr: got %b want %b", o, 8'h00); end
      tick();
      // x0 never forwards
      set_in(mk_r(6, 0, 0), mk_r(0, 1, 2), 1'b1, 1'b0, 1'b0, 1'b0);
      o = obs(); tests++;
      if (o !== 8'h00) begin fails++; $display("FAIL fwd_x0: got %b want %b", o, 8'h00); end
      tick();
   endtask

   task automatic test_load_use();
      // lw x5 in EM, add x6,x7,x5 in FD
      set_in(mk_r(6, 7, 5), mk_lw(5, 1), 1'b1, 1'b0, 1'b0, 1'b0);
      o = obs(); tests++;
      if (o !== 8'hA0) begin fails++; $display("FAIL lu_stall: got %b want %b", o, 8'hA0); end
      tick();
      set_in(mk_r(6, 7, 5), 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      o = obs(); tests++;
      if (o !== 8'h01) begin fails++; $display("FAIL lu_wbfwd: got %b want %b", o, 8'h01); end
      tick();
      set_in(mk_r(6, 7, 5), mk_r(5, 2, 3), 1'b1, 1'b0, 1'b0, 1'b0);
      o = obs(); tests++;
      if (o !== 8'h04) begin fails++; $display("FAIL lu_backrun: got %b want %b", o, 8'h04); end
      tick();
   endtask

   task automatic test_memwait();
`ifdef HAZARD_PERF_CNT_EN
      logic [31:0] c0;
      c0 = stall_cnt;
`endif
      for (int i = 0; i < 3; i++) begin
         set_in(32'd0, mk_sw(5, 1), 1'b0, 1'b0, 1'b1, 1'b0);
         o = obs(); tests++;
         if (o !== 8'hC0) begin fails++; $display("FAIL mw_stall%0d: got %b want %b", i, o, 8'hC0); end
         tick();
      end
      set_in(32'd0, mk_sw(5, 1), 1'b0, 1'b0, 1'b1, 1'b1);
      o = obs(); tests++;
      if (o !== 8'h00) begin fails++; $display("FAIL mw_ready: got %b want %b", o, 8'h00); end
      tick();
      set_in(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      o = obs(); tests++;
      if (o !== 8'h00) begin fails++; $display("FAIL mw_after: got %b want %b", o, 8'h00); end
`ifdef HAZARD_PERF_CNT_EN
      tests++;
      if (stall_cnt !== c0 + 32'd3) begin
         fails++; $display("FAIL mw_cnt: got %0d want %0d", stall_cnt, c0 + 32'd3);
      end
`endif
      tick();
   endtask

   task automatic test_branch();
      set_in(mk_r(6, 5, 7), mk_lw(5, 1), 1'b1, 1'b1, 1'b0, 1'b0);
      o = obs(); tests++;
      if (o !== 8'h10) begin fails++; $display("FAIL br_over_lu: got %b want %b", o, 8'h10); end
      tick();
      set_in(mk_r(6, 5, 7), 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      o = obs(); tests++;
      if (o !== 8'h00) begin fails++; $display("FAIL br_no_lu: got %b want %b", o, 8'h00); end
      tick();
      // branch during a memory wait: flush only when EM finally advances
      set_in(32'd0, mk_lw(5, 1), 1'b1, 1'b1, 1'b1, 1'b0);
      o = obs(); tests++;
      if (o !== 8'hC0) begin fails++; $display("FAIL br_mw_enter: got %b want %b", o, 8'hC0); end
      tick();
      set_in(32'd0, mk_lw(5, 1), 1'b1, 1'b1, 1'b1, 1'b0);
      o = obs(); tests++;
      if (o !== 8'hC0) begin fails++; $display("FAIL br_mw_hold: got %b want %b", o, 8'hC0); end
      tick();
      set_in(32'd0, mk_lw(5, 1), 1'b1, 1'b1, 1'b1, 1'b1);
      o = obs(); tests++;
      if (o !== 8'h10) begin fails++; $display("FAIL br_mw_ready: got %b want %b", o, 8'h10); end
      tick();
   endtask

   task automatic test_reset_mid();
      set_in(32'd0, mk_sw(5, 1), 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      rst = 1'b1;
      set_in(32'd0, mk_sw(5, 1), 1'b0, 1'b0, 1'b1, 1'b0);
      o = obs(); tests++;
      if (o !== 8'h00) begin fails++; $display("FAIL rst_mw_during: got %b want %b", o, 8'h00); end
      tick();
      rst = 1'b0;
      set_in(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      o = obs(); tests++;
      if (o !== 8'h00) begin fails++; $display("FAIL rst_mw_after: got %b want %b", o, 8'h00); end
`ifdef HAZARD_PERF_CNT_EN
      tests++;
      if (stall_cnt !== 32'd0) begin fails++; $display("FAIL rst_cnt: got %0d want 0", stall_cnt); end
`endif
      tick();
      set_in(mk_r(6, 5, 5), mk_lw(5, 1), 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      rst = 1'b1;
      set_in(mk_r(6, 5, 5), 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      set_in(mk_r(6, 5, 5), 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      o = obs(); tests++;
      if (o !== 8'h00) begin fails++; $display("FAIL rst_lu_after: got %b want %b", o, 8'h00); end
      tick();
   endtask

   task automatic test_random();
      logic        waiting, wb_pend, wb_a, wb_b;
      logic [7:0]  exp;
      logic [31:0] fd, em;
      logic        wr, br, req, rdy, ld, ha, hb;
      logic [4:0]  rs1, rs2, rd;
      int          exp_cnt;
      waiting = 1'b0; wb_pend = 1'b0; wb_a = 1'b0; wb_b = 1'b0; exp_cnt = 0;
      rst = 1'b1;
      set_in(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      for (int n = 0; n < 500; n++) begin
         rst = ($urandom_range(39, 0) == 0);
         fd  = mk_r(5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)));
         case ($urandom_range(2, 0))
            0:       em = mk_r(5'($urandom_range(3, 0)), 5'd1, 5'd2);
            1:       em = mk_lw(5'($urandom_range(3, 0)), 5'd1);
            default: em = mk_sw(5'd2, 5'd1);
         endcase
         wr  = ($urandom_range(3, 0) != 0);
         br  = ($urandom_range(5, 0) == 0);
         req = ($urandom_range(3, 0) == 0);
         rdy = $urandom_range(1, 0) != 0;
         set_in(fd, em, wr, br, req, rdy);

         rs1 = fd[19:15]; rs2 = fd[24:20]; rd = em[11:7];
         ld  = (em[6:0] == 7'b0000011);
         ha  = wr && rd != 0 && rd == rs1;
         hb  = wr && rd != 0 && rd == rs2;
         exp = 8'h00;
         if (rst) begin
            waiting = 1'b0; wb_pend = 1'b0; wb_a = 1'b0; wb_b = 1'b0; exp_cnt = 0;
         end else if (wb_pend) begin
            exp[1] = wb_a; exp[0] = wb_b; wb_pend = 1'b0;
         end else if (waiting) begin
            if (!rdy) exp[7:6] = 2'b11;
            else begin exp[4] = br; waiting = 1'b0; end
         end else if (req && !rdy) begin
            exp[7:6] = 2'b11; waiting = 1'b1;
         end else if (br) begin
            exp[4] = 1'b1; exp[3] = ha && !ld; exp[2] = hb && !ld;
         end else if (ld && (ha || hb)) begin
            exp[7] = 1'b1; exp[5] = 1'b1; wb_pend = 1'b1; wb_a = ha; wb_b = hb;
         end else begin
            exp[3] = ha; exp[2] = hb;
         end
         if (exp[7]) exp_cnt++;

         o = obs(); tests++;
         if (o !== exp) begin
            fails++; $display("FAIL rand_cyc%0d: got %b want %b", n, o, exp);
         end
         tests++;
         if (hif.flush && hif.stall_FD) begin
            fails++; $display("FAIL rand_flush_stall%0d: got both asserted want exclusive", n);
         end
         tick();
      end
      rst = 1'b0;
      set_in(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef HAZARD_PERF_CNT_EN
      tests++;
      if (stall_cnt !== 32'(exp_cnt)) begin
         fails++; $display("FAIL rand_cnt: got %0d want %0d", stall_cnt, exp_cnt);
      end
`endif
      tick();
   endtask

   initial begin
      set_in(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      test_reset();
      test_forward();
      test_load_use();
      test_memwait();
      test_branch();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
